// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Function : Bit-serial adder, one full-adder step per clock, LSB first.
//            Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
// Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             c_out_q, c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q,   ovf_d;
`endif

  logic w_bit;
  logic w_carry;

  always_comb begin
    w_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    w_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The a register doubles as the working sum: each consumed operand
        // bit leaves at the LSB while the new sum bit enters at the MSB.
        a_sh_d  = {w_bit, a_sh_q[WIDTH-1:1]};
        b_sh_d  = b_sh_q >> 1;
        carry_d = w_carry;
        cnt_d   = cnt_q + C_ONE;
        if (cnt_q == C_LAST) begin
          sum_d   = {w_bit, a_sh_q[WIDTH-1:1]};
          c_out_d = w_carry;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ w_carry;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Function : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=4);
//            ovf checks follow SERIAL_ADDER_OVF_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       s8, c8, s4, c4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  wire        busy8, done8, cout8, busy4, done4, cout4;
  wire  [7:0] sum8;
  wire  [3:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
  wire        ovf8, ovf4;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .c_in(c8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .c_in(c4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference for the 8-bit instance: m_ph counts cycles since acceptance
  // (0 = waiting, 1..8 = computing, 9 = result cycle); result is plain arithmetic.
  int         m_ph = 0;
  logic [8:0] m_res;
  logic       m_ovf;
  logic [7:0] m_sum = '0;
  logic       m_cout = 1'b0;
  logic       m_ovfq = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_sum = '0; m_cout = 1'b0; m_ovfq = 1'b0;
    end else if (m_ph == 0) begin
      if (s8) begin
        m_res = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
        m_ovf = (a8[7] == b8[7]) && (m_res[7] != a8[7]);
        m_ph  = 1;
      end
    end else if (m_ph == 8) begin
      {m_cout, m_sum} = m_res;
      m_ovfq = m_ovf;
      m_ph   = 9;
    end else if (m_ph == 9) begin
      m_ph = 0;
    end else begin
      m_ph++;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy8}, {31'd0, (m_ph >= 1 && m_ph <= 8)});
      check("done", {31'd0, done8}, {31'd0, (m_ph == 9)});
      check("sum",  {24'd0, sum8},  {24'd0, m_sum});
      check("c_out", {31'd0, cout8}, {31'd0, m_cout});
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", {31'd0, ovf8}, {31'd0, m_ovfq});
`endif
    end
  end

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input bit hold, output int lat, output int nbusy);
    @(posedge clk); #1;
    a8 = ta; b8 = tb; c8 = tc; s8 = 1'b1;
    @(posedge clk); #1;
    if (!hold) s8 = 1'b0;
    lat   = 0;
    nbusy = busy8 ? 1 : 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) nbusy++;
      if (hold && lat == 3) begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
    end
  endtask

  int lat, nbusy, ndone, cyc;
  int t_done[$];

  initial begin
    rst = 1'b1; s8 = 1'b1; s4 = 1'b1;
    a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b1; a4 = '0; b4 = '0; c4 = 1'b0;

    // Reset held two cycles with start asserted
    @(posedge clk); #1; chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_sum",  {24'd0, sum8},  32'h00);
    check("rst_cout", {31'd0, cout8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf",  {31'd0, ovf8},  32'd0);
`endif
    rst = 1'b0; s8 = 1'b0; s4 = 1'b0;

    // Basic add
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, lat, nbusy);
    check("basic_latency", lat, 8);
    check("basic_busy_cycles", nbusy, 8);
    check("basic_sum", {24'd0, sum8}, 32'h96);
    check("basic_cout", {31'd0, cout8}, 32'd0);
    check("model_sum", {24'd0, m_sum}, 32'h96);
    check("model_ovf", {31'd0, m_ovfq}, 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("basic_ovf", {31'd0, ovf8}, 32'd1);
`endif

    // Carry chain, operands scrambled mid-run with start held
    op8(8'hFF, 8'h00, 1'b1, 1'b1, lat, nbusy);
    s8 = 1'b0;
    check("chain_latency", lat, 8);
    check("chain_sum", {24'd0, sum8}, 32'h00);
    check("chain_cout", {31'd0, cout8}, 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("chain_ovf", {31'd0, ovf8}, 32'd0);
`endif

    // Back-to-back with start held
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; s8 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done8) t_done.push_back(i);
    end
    check("b2b_pulses", t_done.size(), 4);
    if (t_done.size() >= 3) begin
      check("b2b_period1", t_done[1] - t_done[0], 10);
      check("b2b_period2", t_done[2] - t_done[1], 10);
    end
    check("b2b_sum", {24'd0, sum8}, 32'h00);
    check("b2b_cout", {31'd0, cout8}, 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("b2b_ovf", {31'd0, ovf8}, 32'd1);
`endif
    s8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Reset sampled on the 4th computing edge
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; s8 = 1'b1;
    @(posedge clk); #1; s8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort_busy", {31'd0, busy8}, 32'd0);
    check("abort_done", {31'd0, done8}, 32'd0);
    check("abort_sum",  {24'd0, sum8},  32'h00);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Randomized traffic, including stray start pulses and rare resets
    ndone = 0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
      s8  = ($urandom_range(0, 3) == 0);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      c8  = 1'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; s8 = 1'b0;
    check("random_activity", {31'd0, (ndone > 50)}, 32'd1);
    repeat (12) @(posedge clk);

    // Exhaustive WIDTH=4
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      logic [4:0] e;
      int         l4;
      v = 9'(i);
      @(posedge clk); #1;
      a4 = v[3:0]; b4 = v[7:4]; c4 = v[8]; s4 = 1'b1;
      @(posedge clk); #1;
      s4 = 1'b0;
      l4 = 0;
      while (!done4 && l4 < 20) begin
        @(posedge clk); #1;
        l4++;
      end
      e = {1'b0, a4} + {1'b0, b4} + {4'd0, c4};
      check("w4_latency", l4, 4);
      check("w4_result", {27'd0, cout4, sum4}, {27'd0, e});
`ifdef SERIAL_ADDER_OVF_EN
      check("w4_ovf", {31'd0, ovf4}, {31'd0, ((a4[3] == b4[3]) && (e[3] != a4[3]))});
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
